// File: rtl/la_capture_core_if.sv
// Readout port of the logic-analyser capture engine.
// The master (host/debug register block) issues rd_en/rd_addr; the slave (capture core) returns
// rd_data/rd_valid one cycle later.
//   rd_en    : read strobe
//   rd_addr  : address relative to the oldest stored sample
//   rd_data  : read data
//   rd_valid : one-cycle pulse, qualifies rd_data
interface la_capture_core_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/la_capture_core.sv
// On-chip logic-analyser capture engine.
// Samples a DATA_W-bit probe bus into a DEPTH-deep circular buffer. Supports a mask/value/edge
// trigger plus an external trigger and a programmable pre-trigger depth. The buffer is read back
// relative to the oldest sample of the capture.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   probe_i        : probe bus
//   arm_i/abort_i  : start (or restart) / cancel a capture, single-cycle pulses
//   ext_trig_i     : external trigger level
//   trig_mask_i    : bits taking part in the trigger
//   trig_value_i   : required bit values
//   trig_edge_i    : masked bits that must transition into their value
//   pretrig_i      : samples kept before the trigger sample
//   rd             : readout port (slave side of la_capture_core_if)
//   state_o        : 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
//   triggered_o    : trigger seen in the current capture
//   done_o         : buffer complete and readable
//   trig_addr_o    : physical address of the trigger sample
module la_capture_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              ext_trig_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [DATA_W-1:0] trig_edge_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  la_capture_core_if.slave  rd,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StWait = 3'd2,
    StPost = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] probe_q, prev_q;
  logic [DATA_W-1:0] mask_q, mask_d, value_q, value_d, edge_q, edge_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;  // pre-trigger count in PRE, remaining post samples in POST
  logic              triggered_q, triggered_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              we;
  logic              level_ok, edge_ok, hit;
  logic [ADDR_W-1:0] rd_phys;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // level_ok also enforces probe == value on the edge bits; edge_ok adds prev != value there.
  assign level_ok = ((probe_q ^ value_q) & mask_q) == '0;
  assign edge_ok  = (~(prev_q ^ value_q) & mask_q & edge_q) == '0;
  assign hit      = (level_ok & edge_ok) | ext_trig_i;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    value_d     = value_q;
    edge_d      = edge_q;
    pretrig_d   = pretrig_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    triggered_d = triggered_q;
    trig_addr_d = trig_addr_q;
    we          = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else if (arm_i) begin
      // pretrig_i is ADDR_W bits wide, so it can never exceed DEPTH-1.
      mask_d      = trig_mask_i;
      value_d     = trig_value_i;
      edge_d      = trig_edge_i;
      pretrig_d   = pretrig_i;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      triggered_d = 1'b0;
      trig_addr_d = '0;
      state_d     = (pretrig_i != '0) ? StPre : StWait;
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StPre: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + One;
          cnt_d    = cnt_q + One;
          if (cnt_q + One == pretrig_q) state_d = StWait;
        end
        StWait: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + One;
          if (hit) begin
            triggered_d = 1'b1;
            trig_addr_d = wr_ptr_q;
            cnt_d       = MaxAddr - pretrig_q;
            state_d     = (pretrig_q == MaxAddr) ? StDone : StPost;
          end
        end
        StPost: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + One;
          cnt_d    = cnt_q - One;
          if (cnt_q == One) state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      probe_q     <= '0;
      prev_q      <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= '0;
      pretrig_q   <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      triggered_q <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      probe_q     <= probe_i;
      prev_q      <= probe_q;
      mask_q      <= mask_d;
      value_q     <= value_d;
      edge_q      <= edge_d;
      pretrig_q   <= pretrig_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      triggered_q <= triggered_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  // Sample buffer: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= probe_q;
  end

  // Oldest sample sits pretrig entries before the trigger sample; ADDR_W arithmetic wraps.
  assign rd_phys = trig_addr_q - pretrig_q + rd.rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd.rd_en;
      if (rd.rd_en) rd_data_q <= mem[rd_phys];
    end
  end

  assign rd.rd_data   = rd_data_q;
  assign rd.rd_valid  = rd_valid_q;
  assign state_o      = state_q;
  assign triggered_o  = triggered_q;
  assign done_o       = (state_q == StDone);
  assign trig_addr_o  = trig_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core at DATA_W=8, DEPTH=16.
module tb_la_capture_core;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned AW  = 4;

  typedef struct {
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    logic [DW-1:0] edg;
    logic [DW-1:0] prev;
    logic [DW-1:0] cur;
    logic          ext;
    logic          exp_hit;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] probe_i;
  logic          arm_i;
  logic          abort_i;
  logic          ext_trig_i;
  logic [DW-1:0] trig_mask_i;
  logic [DW-1:0] trig_value_i;
  logic [DW-1:0] trig_edge_i;
  logic [AW-1:0] pretrig_i;
  logic [2:0]    state_o;
  logic          triggered_o;
  logic          done_o;
  logic [AW-1:0] trig_addr_o;

  logic          auto_cnt;
  int            n_cmp;
  int            n_bad;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] sb_exp;

  la_capture_core_if #(.DATA_W(DW), .ADDR_W(AW)) rd_bus ();

  la_capture_core #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .probe_i      (probe_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .ext_trig_i   (ext_trig_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .trig_edge_i  (trig_edge_i),
    .pretrig_i    (pretrig_i),
    .rd           (rd_bus.slave),
    .state_o      (state_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .trig_addr_o  (trig_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Scoreboard: read expectations are queued at issue and retired when rd_valid shows up.
  always @(negedge clk) begin
    if (rd_bus.rd_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: rd_valid with no read outstanding, data %0h", rd_bus.rd_data);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("rd_data", 32'(rd_bus.rd_data), 32'(sb_exp));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (auto_cnt) probe_i = probe_i + 8'd1;
  endtask

  task automatic setup(input logic [7:0] m, input logic [7:0] v, input logic [7:0] e,
                       input logic [3:0] p);
    trig_mask_i  = m;
    trig_value_i = v;
    trig_edge_i  = e;
    pretrig_i    = p;
  endtask

  task automatic read_burst(input logic [3:0] a0, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      rd_bus.rd_en   = 1'b1;
      rd_bus.rd_addr = a0 + 4'(i);
      sb_q.push_back(base + 8'(i));
      tick();
    end
    rd_bus.rd_en = 1'b0;
    tick();
    tick();
    chk("rd_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done_o && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Counting probe, level trigger on v: checks latency, trig_addr and the full readout.
  task automatic run_count(input logic [7:0] v, input logic [3:0] p);
    logic [7:0] a;
    int         n;
    auto_cnt = 1'b1;
    setup(8'hFF, v, 8'h00, p);
    a     = probe_i;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    n = 0;
    while (!triggered_o && n < 300) begin
      tick();
      n++;
    end
    chk("cnt_triggered", 32'(triggered_o), 32'd1);
    chk("cnt_not_done_at_trig", 32'(done_o), 32'd0);
    wait_done(50, n);
    chk("cnt_done_latency", 32'(n), 32'(15 - int'(p)));
    chk("cnt_trig_addr", 32'(trig_addr_o), 32'(4'(v - a)));
    chk("cnt_state_done", 32'(state_o), 32'd4);
    read_burst(4'd0, 16, v - 8'(p));
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] pv;
    logic [6:0] step;
    logic [6:0] s1;
    int         n;

    vecs[0] = '{mask: 8'hFF, value: 8'h20, edg: 8'h00, prev: 8'h1F, cur: 8'h20, ext: 0, exp_hit: 1};
    vecs[1] = '{mask: 8'hFF, value: 8'h20, edg: 8'h00, prev: 8'h1F, cur: 8'h21, ext: 0, exp_hit: 0};
    vecs[2] = '{mask: 8'hF0, value: 8'hA0, edg: 8'h00, prev: 8'h05, cur: 8'hA7, ext: 0, exp_hit: 1};
    vecs[3] = '{mask: 8'h01, value: 8'h01, edg: 8'h01, prev: 8'h00, cur: 8'h01, ext: 0, exp_hit: 1};
    vecs[4] = '{mask: 8'h01, value: 8'h01, edg: 8'h01, prev: 8'h01, cur: 8'h01, ext: 0, exp_hit: 0};
    vecs[5] = '{mask: 8'h03, value: 8'h03, edg: 8'h01, prev: 8'h02, cur: 8'h03, ext: 0, exp_hit: 1};
    vecs[6] = '{mask: 8'h03, value: 8'h03, edg: 8'h01, prev: 8'h00, cur: 8'h01, ext: 0, exp_hit: 0};
    vecs[7] = '{mask: 8'hFF, value: 8'h55, edg: 8'h00, prev: 8'h00, cur: 8'h00, ext: 1, exp_hit: 1};
    vecs[8] = '{mask: 8'h80, value: 8'h00, edg: 8'h80, prev: 8'h80, cur: 8'h00, ext: 0, exp_hit: 1};
    vecs[9] = '{mask: 8'h80, value: 8'h00, edg: 8'h80, prev: 8'h00, cur: 8'h00, ext: 0, exp_hit: 0};

    n_cmp = 0;
    n_bad = 0;
    auto_cnt = 1'b0;
    rst_n = 1'b0;
    probe_i = '0;
    arm_i = 1'b0;
    abort_i = 1'b0;
    ext_trig_i = 1'b0;
    setup(8'h00, 8'h00, 8'h00, 4'd0);
    rd_bus.rd_en = 1'b0;
    rd_bus.rd_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_triggered", 32'(triggered_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_bus.rd_valid), 32'd0);
    chk("rst_trig_addr", 32'(trig_addr_o), 32'd0);
    chk("rst_rd_data", 32'(rd_bus.rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Counting probe, trigger on 0x20, pretrig 4: readout 1C..2B
    run_count(8'h20, 4'd4);

    // pretrig 0, mask 0: trigger on the first WAIT cycle
    auto_cnt = 1'b1;
    setup(8'h00, 8'h00, 8'h00, 4'd0);
    a = probe_i;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (15) tick();
    chk("p0_not_done_yet", 32'(done_o), 32'd0);
    tick();
    chk("p0_done_after_16", 32'(done_o), 32'd1);
    chk("p0_triggered", 32'(triggered_o), 32'd1);
    chk("p0_trig_addr", 32'(trig_addr_o), 32'd0);
    read_burst(4'd0, 1, a);
    read_burst(4'd15, 1, a + 8'd15);

    // Edge trigger on bit0: held high, then 0, then 1
    auto_cnt = 1'b0;
    step = '0;
    setup(8'h01, 8'h01, 8'h01, 4'd4);
    probe_i = {step, 1'b1};
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step = step + 7'd1;
      probe_i = {step, 1'b1};
      tick();
    end
    chk("edge_state_wait", 32'(state_o), 32'd2);
    chk("edge_no_trig_held", 32'(triggered_o), 32'd0);
    step = step + 7'd1;
    probe_i = {step, 1'b0};
    tick();
    step = step + 7'd1;
    s1 = step;
    probe_i = {step, 1'b1};
    tick();
    chk("edge_no_trig_fall", 32'(triggered_o), 32'd0);
    tick();
    chk("edge_trig_rise", 32'(triggered_o), 32'd1);
    wait_done(50, n);
    chk("edge_done", 32'(done_o), 32'd1);
    read_burst(4'd3, 1, {s1 - 7'd1, 1'b0});
    read_burst(4'd4, 1, {s1, 1'b1});

    // Trigger condition table (pretrig 0, static probes)
    foreach (vecs[i]) begin
      setup(vecs[i].mask, vecs[i].value, vecs[i].edg, 4'd0);
      probe_i = vecs[i].prev;
      tick();
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      tick();
      tick();
      chk($sformatf("vec%0d_idle", i), 32'(triggered_o), 32'd0);
      probe_i = vecs[i].cur;
      tick();
      chk($sformatf("vec%0d_pre", i), 32'(triggered_o), 32'd0);
      ext_trig_i = vecs[i].ext;
      tick();
      ext_trig_i = 1'b0;
      chk($sformatf("vec%0d_hit", i), 32'(triggered_o), 32'(vecs[i].exp_hit));
    end

    // pretrig = DEPTH-1: ext pulse in PRE ignored, ext pulse in WAIT completes at once
    auto_cnt = 1'b1;
    setup(8'hFF, 8'h55, 8'hFF, 4'd15);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (4) tick();
    ext_trig_i = 1'b1;
    tick();
    ext_trig_i = 1'b0;
    chk("pre_state", 32'(state_o), 32'd1);
    chk("pre_ext_ignored", 32'(triggered_o), 32'd0);
    n = 0;
    while (state_o != 3'd2 && n < 40) begin
      tick();
      n++;
    end
    chk("pre_reaches_wait", 32'(state_o), 32'd2);
    tick();
    tick();
    chk("wait_no_trig", 32'(triggered_o), 32'd0);
    pv = probe_i - 8'd1;
    ext_trig_i = 1'b1;
    tick();
    ext_trig_i = 1'b0;
    chk("ext_done_next_edge", 32'(done_o), 32'd1);
    chk("ext_triggered", 32'(triggered_o), 32'd1);
    read_burst(4'd15, 1, pv);
    read_burst(4'd0, 1, pv - 8'd15);

    // Abort in POST, then arm+abort together
    setup(8'h00, 8'h00, 8'h00, 4'd0);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (3) tick();
    chk("abort_in_post", 32'(state_o), 32'd3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    repeat (3) tick();
    chk("abort_done_stays", 32'(done_o), 32'd0);
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    chk("arm_abort_idle", 32'(state_o), 32'd0);

    // Asynchronous reset mid-POST, then a fresh capture
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    repeat (4) tick();
    chk("rst2_in_post", 32'(state_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_state", 32'(state_o), 32'd0);
    chk("rst2_triggered", 32'(triggered_o), 32'd0);
    chk("rst2_done", 32'(done_o), 32'd0);
    chk("rst2_trig_addr", 32'(trig_addr_o), 32'd0);
    chk("rst2_rd_valid", 32'(rd_bus.rd_valid), 32'd0);
    chk("rst2_rd_data", 32'(rd_bus.rd_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_count(probe_i + 8'd20, 4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
